// File: rtl/lcd_bus_writer_if.sv
// lcd_bus_writer_if: command and pixel-word handshakes feeding lcd_bus_writer.
interface lcd_bus_writer_if;
   logic        cmd_valid;
   logic        cmd_dc;
   logic [7:0]  cmd_data;
   logic        cmd_ready;
   logic        px_valid;
   logic [31:0] px_data;
   logic        px_ready;
   modport master (output cmd_valid, cmd_dc, cmd_data, px_valid, px_data, input cmd_ready, px_ready);
   modport slave (input cmd_valid, cmd_dc, cmd_data, px_valid, px_data, output cmd_ready, px_ready);
endinterface

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: pixel-word FIFO feeding an 8080-style write-only LCD bus.
// Define LCD_BUS16_EN for a 16-bit data bus (two writes per pixel word instead of four).
module lcd_bus_writer #(
   parameter int FIFO_DEPTH = 16,
   parameter int WR_LOW     = 2,
   parameter int WR_HIGH    = 2
) (
   input  logic                         AXI_ACLK,
   input  logic                         AXI_ARESET,
   lcd_bus_writer_if.slave              bus,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         busy,
   output logic [3:0]                   lcd_ctl,
`ifdef LCD_BUS16_EN
   output logic [15:0]                  lcd_data
`else
   output logic [7:0]                   lcd_data
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [15:0] LOW_END  = 16'(WR_LOW - 1);
   localparam logic [15:0] HIGH_END = 16'(WR_HIGH - 1);
   typedef enum logic [1:0] {IDLE, WR_L, WR_H} state_t;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        dc_q, dc_d, is_cmd_q, is_cmd_d;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [LW-1:0] count_q;
   logic        push, pop, empty, full;
   logic [3:0]  ctl_q;
`ifdef LCD_BUS16_EN
   localparam logic [1:0] LAST = 2'd1;
   logic [15:0] beat, data_q;
   assign beat = is_cmd_q ? {8'h00, cmd_q} : (idx_q[0] ? word_q[31:16] : word_q[15:0]);
`else
   localparam logic [1:0] LAST = 2'd3;
   logic [7:0] beat, data_q;
   // high byte of each pixel goes first: shifts of 8, 0, 24, 16
   assign beat = is_cmd_q ? cmd_q : 8'(word_q >> {idx_q[1], ~idx_q[0], 3'b000});
`endif
   assign empty         = count_q == '0;
   assign full          = count_q == LW'(FIFO_DEPTH);
   assign bus.px_ready  = !AXI_ARESET && !full;
   assign bus.cmd_ready = !AXI_ARESET && state_q == IDLE && empty;
   assign push          = bus.px_valid && bus.px_ready;
   assign fifo_level    = count_q;
   assign busy          = state_q != IDLE || !empty;
   assign lcd_ctl       = ctl_q;
   assign lcd_data      = data_q;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      word_d   = word_q;
      cmd_d    = cmd_q;
      dc_d     = dc_q;
      is_cmd_d = is_cmd_q;
      pop      = 1'b0;
      case (state_q)
         IDLE:
            if (!empty) begin
               pop      = 1'b1;
               word_d   = mem[rp_q];
               idx_d    = '0;
               is_cmd_d = 1'b0;
               cnt_d    = '0;
               state_d  = WR_L;
            end else if (bus.cmd_valid) begin
               cmd_d    = bus.cmd_data;
               dc_d     = bus.cmd_dc;
               is_cmd_d = 1'b1;
               cnt_d    = '0;
               state_d  = WR_L;
            end
         WR_L: begin
            cnt_d   = cnt_q == LOW_END ? '0 : cnt_q + 16'd1;
            state_d = cnt_q == LOW_END ? WR_H : WR_L;
         end
         WR_H:
            if (cnt_q != HIGH_END) cnt_d = cnt_q + 16'd1;
            else begin
               cnt_d   = '0;
               state_d = WR_L;
               if (!is_cmd_q && idx_q != LAST) idx_d = idx_q + 2'd1;
               else if (!empty) begin
                  pop      = 1'b1;
                  word_d   = mem[rp_q];
                  idx_d    = '0;
                  is_cmd_d = 1'b0;
               end else state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge AXI_ACLK) if (push) mem[wp_q] <= bus.px_data;
   // bus pins are driven from the current state, one cycle behind the FSM
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         word_q   <= '0;
         cmd_q    <= '0;
         dc_q     <= 1'b0;
         is_cmd_q <= 1'b0;
         wp_q     <= '0;
         rp_q     <= '0;
         count_q  <= '0;
         ctl_q    <= 4'b1011;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
         cmd_q    <= cmd_d;
         dc_q     <= dc_d;
         is_cmd_q <= is_cmd_d;
         wp_q     <= wp_q + AW'(push);
         rp_q     <= rp_q + AW'(pop);
         count_q  <= count_q + LW'(push) - LW'(pop);
         ctl_q    <= {state_q == IDLE, state_q == IDLE ? ctl_q[2] : (is_cmd_q ? dc_q : 1'b1), state_q != WR_L, 1'b1};
         data_q   <= state_q == IDLE ? data_q : beat;
      end
   end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: scoreboard bench; expected bus writes and CS_n burst lengths are
// queued at stimulus time and checked by a monitor watching WR_n/CS_n rising edges.
module tb_lcd_bus_writer;
   localparam int FIFO_DEPTH = 16;
   localparam int WR_LOW = 2;
   localparam int WR_HIGH = 2;
`ifdef LCD_BUS16_EN
   localparam int DW = 16;
   localparam int NB = 2;
   localparam logic [15:0] FIRST_1234 = 16'h5678;
`else
   localparam int DW = 8;
   localparam int NB = 4;
   localparam logic [7:0] FIRST_1234 = 8'h56;
`endif
   localparam int WORD_CYC = NB * (WR_LOW + WR_HIGH);
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   logic busy;
   logic [3:0] lcd_ctl;
   logic [DW-1:0] lcd_data;
   int tests = 0, fails = 0, wr_falls = 0, stalls = 0;
   logic [DW:0] exp_q[$];
   int len_q[$];
   lcd_bus_writer_if bus();
   lcd_bus_writer #(.FIFO_DEPTH(FIFO_DEPTH), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) dut (
      .AXI_ACLK(clk), .AXI_ARESET(rst), .bus(bus), .fifo_level(fifo_level),
      .busy(busy), .lcd_ctl(lcd_ctl), .lcd_data(lcd_data));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // monitor: a write is latched on WR_n rising while CS_n is still low
   logic prev_wr = 1'b1, prev_cs = 1'b1;
   int low_len = 0, cs_len = 0;
   always @(negedge clk) begin
      if (rst) begin
         low_len = 0;
         cs_len = 0;
      end else begin
         if (prev_wr && !lcd_ctl[1]) wr_falls++;
         if (!lcd_ctl[1]) low_len++;
         if (!prev_wr && lcd_ctl[1] && !lcd_ctl[3]) begin
            if (exp_q.size() == 0) chk("unexpected_write", {lcd_ctl[2], lcd_data}, '1);
            else chk("write", {lcd_ctl[2], lcd_data}, exp_q.pop_front());
            chk("wr_low_len", low_len, WR_LOW);
         end
         if (lcd_ctl[1]) low_len = 0;
         if (!lcd_ctl[3]) cs_len++;
         if (!prev_cs && lcd_ctl[3]) begin
            if (len_q.size() == 0) chk("unexpected_cs_burst", cs_len, 0);
            else chk("cs_len", cs_len, len_q.pop_front());
            cs_len = 0;
         end
      end
      prev_wr = lcd_ctl[1];
      prev_cs = lcd_ctl[3];
   end
   task automatic exp_word(input logic [31:0] w);
`ifdef LCD_BUS16_EN
      exp_q.push_back({1'b1, w[15:0]});
      exp_q.push_back({1'b1, w[31:16]});
`else
      exp_q.push_back({1'b1, w[15:8]});
      exp_q.push_back({1'b1, w[7:0]});
      exp_q.push_back({1'b1, w[31:24]});
      exp_q.push_back({1'b1, w[23:16]});
`endif
   endtask
   task automatic push_word(input logic [31:0] w);
      int n = 0;
      bus.px_valid = 1'b1;
      bus.px_data = w;
      if (!bus.px_ready) begin
         stalls++;
         chk("full_level", fifo_level, FIFO_DEPTH);
      end
      while (!bus.px_ready && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) chk("px_ready_timeout", bus.px_ready, 1);
      tick();
      bus.px_valid = 1'b0;
      exp_word(w);
   endtask
   task automatic send_cmd(input logic dc, input logic [7:0] d, output int waited);
      logic [DW:0] e = '0;
      waited = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_dc = dc;
      bus.cmd_data = d;
      while (!bus.cmd_ready && waited < 500) begin
         tick();
         waited++;
      end
      if (waited >= 500) chk("cmd_ready_timeout", bus.cmd_ready, 1);
      chk("cmd_accept_level", fifo_level, 0);
      tick();
      bus.cmd_valid = 1'b0;
      e[DW] = dc;
      e[7:0] = d;
      exp_q.push_back(e);
      len_q.push_back(WR_LOW + WR_HIGH);
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((busy || !lcd_ctl[3] || exp_q.size() != 0 || len_q.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) chk("idle_timeout", busy, 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int w, n, falls;
      bus.cmd_valid = 1'b0;
      bus.cmd_dc = 1'b0;
      bus.cmd_data = '0;
      bus.px_valid = 1'b0;
      bus.px_data = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", lcd_ctl, 4'b1011);
      chk("rst_data", lcd_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_px_ready", bus.px_ready, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      rst = 1'b0;
      #1;
      chk("rel_px_ready", bus.px_ready, 1);
      chk("rel_cmd_ready", bus.cmd_ready, 1);
      tick();
      send_cmd(1'b0, 8'h2C, w);
      wait_idle();
      bus.px_valid = 1'b1;
      bus.px_data = 32'h1234_5678;
      tick();
      bus.px_valid = 1'b0;
      exp_word(32'h1234_5678);
      len_q.push_back(WORD_CYC);
      chk("lat_e0_level", fifo_level, 1);
      chk("lat_e0_ctl", lcd_ctl, 4'b1011);
      tick();
      chk("lat_e1_ctl", lcd_ctl, 4'b1011);
      chk("lat_e1_level", fifo_level, 0);
      tick();
      chk("lat_e2_ctl", lcd_ctl, 4'b0101);
      chk("lat_e2_data", lcd_data, FIRST_1234);
      wait_idle();
      len_q.push_back(WORD_CYC);
      push_word(32'hF800_07E0);
      wait_idle();
      len_q.push_back(20 * WORD_CYC);
      stalls = 0;
      for (int i = 0; i < 20; i++) push_word(32'hA050_0F00 + i * 32'h0103_0507);
      wait_idle();
      chk("bp_stalled", stalls > 0, 1);
      len_q.push_back(3 * WORD_CYC);
      push_word(32'h0102_0304);
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
      chk("cmd_blocked", bus.cmd_ready, 0);
      send_cmd(1'b1, 8'hA5, w);
      chk("cmd_wait", w >= 2 * WORD_CYC, 1);
      wait_idle();
      push_word(32'hDEAD_BEEF);
      push_word(32'hCAFE_F00D);
      n = 0;
      while (lcd_ctl[1] && n < 50) begin
         tick();
         n++;
      end
      chk("abort_wr_low", lcd_ctl[1], 0);
      rst = 1'b1;
      exp_q.delete();
      len_q.delete();
      tick();
      chk("abort_ctl", lcd_ctl, 4'b1011);
      chk("abort_data", lcd_data, 0);
      chk("abort_level", fifo_level, 0);
      tick();
      rst = 1'b0;
      falls = wr_falls;
      repeat (40) tick();
      chk("abort_no_wr", wr_falls - falls, 0);
      chk("abort_busy", busy, 0);
      chk("sb_empty", exp_q.size() + len_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
